// File: rtl/onewire_txn_engine.sv
// onewire_txn_engine: single-master 1-Wire command engine.
// Generates write/read bit slots and reset/presence pulses on an open-drain bus.
// Bytes are shifted LSB first, and every bus bit is folded into a Dallas/Maxim
// CRC-8 that keeps running across commands.
module onewire_txn_engine #(
   parameter int T_SLOT   = 60,
   parameter int T_REC    = 10,
   parameter int T_LOW1   = 6,
   parameter int T_LOW0   = 60,
   parameter int T_SAMPLE = 15,
   parameter int T_RSTL   = 480,
   parameter int T_RSTH   = 480,
   parameter int T_MSP    = 70
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] data_in,
   input  logic       ow_in,
   output logic       ow_drive_low,
   output logic [7:0] data_out,
   output logic [7:0] crc,
   output logic       busy,
   output logic       done,
   output logic [7:0] status
);

   // A 16-bit phase counter covers every timing parameter up to 65535 cycles.
   localparam int CW = 16;
   localparam logic [CW-1:0] SLOT_LAST = CW'(T_SLOT + T_REC - 1);
   localparam logic [CW-1:0] SAMPLE_AT = CW'(T_SAMPLE);
   localparam logic [CW-1:0] LOW1_LEN  = CW'(T_LOW1);
   localparam logic [CW-1:0] LOW0_LEN  = CW'(T_LOW0);
   localparam logic [CW-1:0] RSTL_LAST = CW'(T_RSTL - 1);
   localparam logic [CW-1:0] RSTH_LAST = CW'(T_RSTH - 1);
   localparam logic [CW-1:0] MSP_AT    = CW'(T_MSP);

   localparam logic [1:0] CMD_WRITE = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_RESET = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SLOT     = 3'd1,
      ST_RST_LOW  = 3'd2,
      ST_RST_WAIT = 3'd3,
      ST_FINISH   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    cmd_q, cmd_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_out_q, data_out_d;
   logic [7:0]    crc_q, crc_d;
   logic          pres_smp_q, pres_smp_d;
   logic          presence_q, presence_d;
   logic          nopres_q, nopres_d;
   logic          done_st_q, done_st_d;
   logic          accept;

   // One bit of the reflected x^8+x^5+x^4+1 CRC.
   function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic b);
      logic [7:0] r;
      r = {1'b0, c[7:1]};
      if (c[0] ^ b) begin
         r = r ^ 8'h8C;
      end
      return r;
   endfunction

   // State and datapath registers; reset releases the bus at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         cmd_q      <= '0;
         shift_q    <= '0;
         data_out_q <= '0;
         crc_q      <= '0;
         pres_smp_q <= 1'b0;
         presence_q <= 1'b0;
         nopres_q   <= 1'b0;
         done_st_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         cmd_q      <= cmd_d;
         shift_q    <= shift_d;
         data_out_q <= data_out_d;
         crc_q      <= crc_d;
         pres_smp_q <= pres_smp_d;
         presence_q <= presence_d;
         nopres_q   <= nopres_d;
         done_st_q  <= done_st_d;
      end
   end

   // Next-state and datapath update; IDLE and FINISH both accept a new command.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      cmd_d      = cmd_q;
      shift_d    = shift_q;
      data_out_d = data_out_q;
      crc_d      = crc_q;
      pres_smp_d = pres_smp_q;
      presence_d = presence_q;
      nopres_d   = nopres_q;
      done_st_d  = done_st_q;
      accept     = start && (state_q == ST_IDLE || state_q == ST_FINISH);

      case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (state_q == ST_FINISH) begin
               done_st_d = 1'b1;
            end
            state_d = ST_IDLE;
            if (accept) begin
               cmd_d     = cmd;
               shift_d   = data_in;
               done_st_d = 1'b0;
               nopres_d  = 1'b0;
               cnt_d     = '0;
               bit_d     = '0;
               case (cmd)
                  CMD_WRITE, CMD_READ: state_d = ST_SLOT;
                  CMD_RESET:           state_d = ST_RST_LOW;
                  default: begin
                     state_d = ST_FINISH;
                     crc_d   = 8'h00;
                  end
               endcase
            end
         end

         ST_SLOT: begin
            // Read bits enter from the top so the first bit ends up in bit 0.
            if (cmd_q == CMD_READ && cnt_q == SAMPLE_AT) begin
               shift_d = {ow_in, shift_q[7:1]};
               crc_d   = crc8_bit(crc_q, ow_in);
            end
            if (cnt_q == SLOT_LAST) begin
               cnt_d = '0;
               bit_d = bit_q + 3'd1;
               if (cmd_q == CMD_WRITE) begin
                  crc_d   = crc8_bit(crc_q, shift_q[0]);
                  shift_d = {1'b0, shift_q[7:1]};
               end
               if (bit_q == 3'd7) begin
                  state_d = ST_FINISH;
                  if (cmd_q == CMD_READ) begin
                     data_out_d = shift_d;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RST_LOW: begin
            if (cnt_q == RSTL_LAST) begin
               cnt_d   = '0;
               state_d = ST_RST_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RST_WAIT: begin
            if (cnt_q == MSP_AT) begin
               pres_smp_d = !ow_in;
            end
            if (cnt_q == RSTH_LAST) begin
               state_d    = ST_FINISH;
               presence_d = pres_smp_d;
               nopres_d   = !pres_smp_d;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; the bus is only pulled during slot low phases and RST_LOW.
   always_comb begin
      logic [CW-1:0] low_len;
      low_len      = (cmd_q == CMD_WRITE && !shift_q[0]) ? LOW0_LEN : LOW1_LEN;
      ow_drive_low = ((state_q == ST_SLOT) && (cnt_q < low_len)) || (state_q == ST_RST_LOW);
      busy         = (state_q == ST_SLOT) || (state_q == ST_RST_LOW) || (state_q == ST_RST_WAIT);
      done         = (state_q == ST_FINISH);
      data_out     = data_out_q;
      crc          = crc_q;
      status       = {1'b0, cmd_q, nopres_q, (crc_q == 8'h00), (done_st_q | done), busy, presence_q};
   end

endmodule

// File: tb/tb_onewire_txn_engine.sv
// Directed bench for onewire_txn_engine with default timing parameters.
module tb_onewire_txn_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] cmd;
   logic [7:0] data_in;
   logic       ow_in;
   logic       ow_drive_low;
   logic [7:0] data_out;
   logic [7:0] crc;
   logic       busy;
   logic       done;
   logic [7:0] status;

   int n_checks = 0;
   int n_fail   = 0;
   int pw[8];
   int ps[8];
   int np;
   int done_k;
   int busy1;
   int ow_mode;
   int inj_k;
   int exp_w[8];
   int done_cnt;

   onewire_txn_engine dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cmd          (cmd),
      .data_in      (data_in),
      .ow_in        (ow_in),
      .ow_drive_low (ow_drive_low),
      .data_out     (data_out),
      .crc          (crc),
      .busy         (busy),
      .done         (done),
      .status       (status)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bus level for observation index k (k = 1 is the first cycle after acceptance).
   function automatic logic ow_level(input int k);
      int b;
      int c;
      b = (k - 1) / 70;
      c = (k - 1) % 70;
      case (ow_mode)
         1: return !(k >= 1 && b >= 2 && b <= 5 && c >= 10 && c <= 40);
         2: return !((k - 481) >= 20 && (k - 481) <= 150);
         default: return 1'b1;
      endcase
   endfunction

   // Issue one command and follow it until done, recording bus low pulses.
   task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input int budget);
      logic prev;
      cmd     = c;
      data_in = d;
      start   = 1'b1;
      ow_in   = 1'b1;
      @(negedge clk);
      np     = 0;
      done_k = 0;
      busy1  = busy;
      prev   = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         if (ow_drive_low && !prev && np < 8) ps[np] = k;
         if (!ow_drive_low && prev) begin
            if (np < 8) pw[np] = k - ps[np];
            np++;
         end
         prev = ow_drive_low;
         if (done) begin
            done_k = k;
            break;
         end
         start = (k == inj_k);
         if (k == inj_k) cmd = 2'b11;
         ow_in = ow_level(k);
         @(negedge clk);
      end
      start = 1'b0;
      $display("txn cmd=%0d data_in=0x%02h done_k=%0d pulses=%0d crc=0x%02h data_out=0x%02h status=0x%02h",
               c, d, done_k, np, crc, data_out, status);
   endtask

   initial begin
      exp_w   = '{6, 60, 6, 60, 60, 6, 60, 6};
      rst     = 1'b1;
      start   = 1'b0;
      cmd     = 2'b00;
      data_in = 8'h00;
      ow_in   = 1'b1;
      ow_mode = 0;
      inj_k   = 0;
      repeat (3) @(negedge clk);
      check("rst_drive", ow_drive_low, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data_out", data_out, 8'h00);
      check("rst_crc", crc, 8'h00);
      check("rst_status", status, 8'h08);
      rst = 1'b0;
      @(negedge clk);

      // WRITE 0xA5 from CRC 0x00
      run_cmd(2'b00, 8'hA5, 2000);
      check("wr_a5_busy1", busy1, 1);
      check("wr_a5_done_k", done_k, 561);
      check("wr_a5_npulse", np, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("wr_a5_width%0d", i), pw[i], exp_w[i]);
         check($sformatf("wr_a5_start%0d", i), ps[i], 1 + 70 * i);
      end
      check("wr_a5_crc", crc, 8'h90);
      check("wr_a5_data_out", data_out, 8'h00);
      check("wr_a5_status", status, 8'h04);

      // CRC_CLEAR accepted in the done cycle, then WRITE 0x01 and 0x5E
      run_cmd(2'b11, 8'h00, 10);
      check("clr_done_k", done_k, 1);
      check("clr_busy1", busy1, 0);
      check("clr_crc", crc, 8'h00);
      check("clr_status", status, 8'h6C);
      check("clr_npulse", np, 0);
      run_cmd(2'b00, 8'h01, 2000);
      check("wr_01_done_k", done_k, 561);
      check("wr_01_crc", crc, 8'h5E);
      check("wr_01_status", status, 8'h04);
      run_cmd(2'b00, 8'h5E, 2000);
      check("wr_5e_crc", crc, 8'h00);
      check("wr_5e_status", status, 8'h0C);

      // READ with bits 2..5 pulled low by a slave
      ow_mode = 1;
      run_cmd(2'b01, 8'h00, 2000);
      check("rd_done_k", done_k, 561);
      check("rd_data_out", data_out, 8'hC3);
      check("rd_crc", crc, 8'h28);
      check("rd_npulse", np, 8);
      check("rd_width0", pw[0], 6);
      check("rd_width7", pw[7], 6);
      check("rd_status", status, 8'h24);

      // RESET with a presence pulse, then with none
      ow_mode = 2;
      run_cmd(2'b10, 8'h00, 2000);
      check("rs_p_done_k", done_k, 961);
      check("rs_p_npulse", np, 1);
      check("rs_p_width", pw[0], 480);
      check("rs_p_status", status, 8'h45);
      check("rs_p_crc", crc, 8'h28);
      ow_mode = 0;
      run_cmd(2'b10, 8'h00, 2000);
      check("rs_np_done_k", done_k, 961);
      check("rs_np_status", status, 8'h54);
      check("rs_np_data_out", data_out, 8'hC3);

      // CRC_CLEAR strobed mid-WRITE must be ignored
      inj_k = 100;
      run_cmd(2'b00, 8'hFF, 2000);
      inj_k = 0;
      check("ign_done_k", done_k, 561);
      check("ign_crc", crc, 8'hD4);
      check("ign_status", status, 8'h04);

      // Reset during the third slot low phase
      cmd     = 2'b00;
      data_in = 8'h00;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (149) @(negedge clk);
      check("ab_pre_drive", ow_drive_low, 1);
      check("ab_pre_data_out", data_out, 8'hC3);
      rst = 1'b1;
      #1;
      check("ab_drive", ow_drive_low, 0);
      check("ab_busy", busy, 0);
      check("ab_data_out", data_out, 8'h00);
      check("ab_done", done, 0);
      @(negedge clk);
      rst      = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 700; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("ab_no_done", done_cnt, 0);
      check("ab_status", status, 8'h08);
      check("ab_crc", crc, 8'h00);
      $display("txn abort done_pulses=%0d status=0x%02h", done_cnt, status);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
